// File: rtl/uart_pkg.sv
// Shared types for the parametrised UART receiver.
// State encoding, parity modes and the FIFO entry layout.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  localparam int MAX_DATA_BITS = 9;

  typedef struct packed {
    logic [MAX_DATA_BITS-1:0] data;
    logic                     perr;
    logic                     ferr;
  } rx_entry_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Consumer-side handshake of the UART receive FIFO.
// The receiver is master; the consumer logic is slave.
interface uart_rx_fifo_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] m_data;
  logic                 m_perr;
  logic                 m_ferr;
  logic                 m_valid;
  logic                 m_ready;

  modport master (
    output m_data, m_perr, m_ferr, m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data, m_perr, m_ferr, m_valid,
    output m_ready
  );
endinterface

// File: rtl/rx_fifo.sv
// Synchronous FIFO with extra-bit pointers.
// dout keeps showing the last head while empty.
module rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wrPtr;
  logic [AW:0]      rdPtr;
  logic [WIDTH-1:0] lastHead;

  assign empty = (wrPtr == rdPtr);
  assign full  = (wrPtr[AW] != rdPtr[AW]) &&
                 (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign dout  = empty ? lastHead : mem[rdPtr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      lastHead <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop && !empty) rdPtr <= rdPtr + 1'b1;
      lastHead <= dout;
    end
  end
endmodule

// File: rtl/uart_rx_fifo.sv
// Parametrised UART receiver feeding a receive FIFO.
// Flags parity/framing errors and reports dropped frames.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int MSB_FIRST    = 0,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic           clkM,
  input  logic           rst_nM,
  input  logic           rxM,
  uart_rx_fifo_if.master rxIf,
  output logic           overrun,
  output logic           busy
);
  import uart_pkg::*;

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  rx_state_t state, stateN;
  logic [1:0] rxSync;
  logic [1:0] fill;
  logic rxPrev, rxS, fall, tick;
  logic [CW-1:0] cnt, cntN;
  logic [3:0] bitIdx, bitN;
  logic [DATA_BITS-1:0] shReg, shN;
  logic perr, perrN, ferr, ferrN;
  logic frameDone;
  logic fifoFull, fifoEmpty, fifoPush, fifoPop;
  rx_entry_t wrEntry, head;
  logic unusedHead;

  assign rxS  = rxSync[1];
  // rxPrev only goes high once the line is seen high after reset
  assign fall = fill[1] & rxPrev & ~rxS;
  assign tick = (cnt == BIT_M1);
  assign busy = (state != RX_IDLE);

  always_ff @(posedge clkM or negedge rst_nM) begin
    if (!rst_nM) begin
      rxSync <= 2'b11;
      fill   <= 2'b00;
      rxPrev <= 1'b0;
      state  <= RX_IDLE;
      cnt    <= '0;
      bitIdx <= '0;
      shReg  <= '0;
      perr   <= 1'b0;
      ferr   <= 1'b0;
    end else begin
      rxSync <= {rxSync[0], rxM};
      fill   <= {fill[0], 1'b1};
      rxPrev <= fill[1] ? rxS : 1'b0;
      state  <= stateN;
      cnt    <= cntN;
      bitIdx <= bitN;
      shReg  <= shN;
      perr   <= perrN;
      ferr   <= ferrN;
    end
  end

  always_comb begin
    stateN    = state;
    cntN      = cnt + 1'b1;
    bitN      = bitIdx;
    shN       = shReg;
    perrN     = perr;
    ferrN     = ferr;
    frameDone = 1'b0;
    unique case (state)
      RX_IDLE: begin
        cntN = '0;
        if (fall) begin
          stateN = RX_START;
          bitN   = '0;
          perrN  = 1'b0;
          ferrN  = 1'b0;
        end
      end
      RX_START: begin
        if (cnt == HALF_M1) begin
          cntN   = '0;
          stateN = rxS ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (tick) begin
          cntN = '0;
          bitN = bitIdx + 1'b1;
          shN  = (MSB_FIRST != 0) ?
                 {shReg[DATA_BITS-2:0], rxS} :
                 {rxS, shReg[DATA_BITS-1:1]};
          if (bitIdx == LAST_DATA) begin
            bitN   = '0;
            stateN = (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
          end
        end
      end
      RX_PARITY: begin
        if (tick) begin
          cntN   = '0;
          perrN  = (PARITY == PAR_ODD) ? ~(^shReg ^ rxS)
                                       : (^shReg ^ rxS);
          stateN = RX_STOP;
        end
      end
      RX_STOP: begin
        if (tick) begin
          cntN  = '0;
          ferrN = ferr | ~rxS;
          if (bitIdx == LAST_STOP) begin
            stateN    = RX_IDLE;
            frameDone = 1'b1;
          end else begin
            bitN = bitIdx + 1'b1;
          end
        end
      end
      default: stateN = RX_IDLE;
    endcase
  end

  always_comb begin
    wrEntry = '0;
    wrEntry.data[DATA_BITS-1:0] = shReg;
    wrEntry.perr = perr;
    wrEntry.ferr = ferrN;
  end

  // a pop in the same cycle frees the slot the new frame needs
  assign fifoPop  = ~fifoEmpty & rxIf.m_ready;
  assign fifoPush = frameDone & (~fifoFull | fifoPop);
  assign overrun  = frameDone & fifoFull & ~fifoPop;

  rx_fifo #(
    .WIDTH($bits(rx_entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) uFifo (
    .clk  (clkM),
    .rst_n(rst_nM),
    .push (fifoPush),
    .din  (wrEntry),
    .full (fifoFull),
    .pop  (fifoPop),
    .dout (head),
    .empty(fifoEmpty)
  );

  assign rxIf.m_valid = ~fifoEmpty;
  assign rxIf.m_data  = head.data[DATA_BITS-1:0];
  assign rxIf.m_perr  = head.perr;
  assign rxIf.m_ferr  = head.ferr;
  assign unusedHead   = ^head;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo across three parameter sets.
// A: defaults; B: 16 clk/bit even parity; C: 7O2 MSB-first depth 2.
module tb_uart_rx_fifo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rxA = 1'b1, rxB = 1'b1, rxC = 1'b1;
  logic ovA, ovB, ovC, busyA, busyB, busyC;
  int checks = 0;
  int errors = 0;
  int ovCntB = 0;
  int ovCntC = 0;

  uart_rx_fifo_if #(.DATA_BITS(8)) ifA ();
  uart_rx_fifo_if #(.DATA_BITS(8)) ifB ();
  uart_rx_fifo_if #(.DATA_BITS(7)) ifC ();

  always #5 clk = ~clk;

  uart_rx_fifo dutA (
    .clkM(clk), .rst_nM(rst_n), .rxM(rxA),
    .rxIf(ifA), .overrun(ovA), .busy(busyA)
  );

  uart_rx_fifo #(
    .CLKS_PER_BIT(16), .PARITY(2)
  ) dutB (
    .clkM(clk), .rst_nM(rst_n), .rxM(rxB),
    .rxIf(ifB), .overrun(ovB), .busy(busyB)
  );

  uart_rx_fifo #(
    .CLKS_PER_BIT(12), .DATA_BITS(7), .PARITY(1),
    .STOP_BITS(2), .MSB_FIRST(1), .FIFO_DEPTH(2)
  ) dutC (
    .clkM(clk), .rst_nM(rst_n), .rxM(rxC),
    .rxIf(ifC), .overrun(ovC), .busy(busyC)
  );

  always @(negedge clk) begin
    if (ovB) ovCntB <= ovCntB + 1;
    if (ovC) ovCntC <= ovCntC + 1;
  end

  task automatic setRx(input int dut, input logic b);
    if (dut == 0) rxA = b;
    else if (dut == 1) rxB = b;
    else rxC = b;
  endtask

  task automatic sendSeq(input int dut, input int cpb,
                         input logic [15:0] seq, input int n);
    for (int i = 0; i < n; i++) begin
      setRx(dut, seq[i]);
      repeat (cpb) @(negedge clk);
    end
  endtask

  task automatic pop(input int dut);
    if (dut == 0) ifA.m_ready = 1'b1;
    else if (dut == 1) ifB.m_ready = 1'b1;
    else ifC.m_ready = 1'b1;
    @(negedge clk);
    ifA.m_ready = 1'b0;
    ifB.m_ready = 1'b0;
    ifC.m_ready = 1'b0;
  endtask

  function automatic logic [15:0] mkA(input logic [7:0] d);
    return 16'({1'b1, d, 1'b0});
  endfunction

  function automatic logic [15:0] mkB(input logic [7:0] d,
                                      input logic p, input logic s);
    return 16'({s, p, d, 1'b0});
  endfunction

  function automatic logic [15:0] mkC(input logic [6:0] d,
                                      input logic p, input logic s2);
    logic [15:0] s;
    s = '1;
    s[0] = 1'b0;
    for (int i = 0; i < 7; i++) s[1+i] = d[6-i];
    s[8] = p;
    s[9] = 1'b1;
    s[10] = s2;
    return s;
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({busyA, busyB, busyC} !== 3'b000) begin
      errors++; $display("FAIL rst_busy got %b exp 000", {busyA, busyB, busyC});
    end
    checks++;
    if ({ifA.m_valid, ifB.m_valid, ifC.m_valid} !== 3'b000) begin
      errors++; $display("FAIL rst_valid got %b exp 000", {ifA.m_valid, ifB.m_valid, ifC.m_valid});
    end
    checks++;
    if ({ifA.m_data, ifA.m_perr, ifA.m_ferr, ovA} !== 11'h0) begin
      errors++; $display("FAIL rst_headA got %h exp 0", {ifA.m_data, ifA.m_perr, ifA.m_ferr, ovA});
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({busyA, busyB, busyC, ovB, ovC} !== 5'b0) begin
      errors++; $display("FAIL post_rst_idle got %b exp 0", {busyA, busyB, busyC, ovB, ovC});
    end
  endtask

  task automatic test_timing();
    fork
      sendSeq(0, 434, mkA(8'hB5), 10);
      begin
        repeat (2) @(negedge clk);
        checks++;
        if (busyA !== 1'b0) begin
          errors++; $display("FAIL busy_t1 got %b exp 0", busyA);
        end
        @(negedge clk);
        checks++;
        if (busyA !== 1'b1) begin
          errors++; $display("FAIL busy_t2 got %b exp 1", busyA);
        end
        repeat (4122) @(negedge clk);
        checks++;
        if (ifA.m_valid !== 1'b0) begin
          errors++; $display("FAIL valid_t4124 got %b exp 0", ifA.m_valid);
        end
        @(negedge clk);
        checks++;
        if ({ifA.m_valid, busyA} !== 2'b10) begin
          errors++; $display("FAIL valid_busy_t4125 got %b exp 10", {ifA.m_valid, busyA});
        end
        checks++;
        if ({ifA.m_data, ifA.m_perr, ifA.m_ferr} !== {8'hB5, 2'b00}) begin
          errors++; $display("FAIL headA_b5 got %h exp %h", {ifA.m_data, ifA.m_perr, ifA.m_ferr}, {8'hB5, 2'b00});
        end
      end
    join
    pop(0);
    checks++;
    if ({ifA.m_valid, ifA.m_data} !== {1'b0, 8'hB5}) begin
      errors++; $display("FAIL popA_hold got %h exp 0b5", {ifA.m_valid, ifA.m_data});
    end
  endtask

  task automatic test_glitch();
    fork
      begin
        rxA = 1'b0;
        repeat (100) @(negedge clk);
        rxA = 1'b1;
      end
      begin
        repeat (50) @(negedge clk);
        checks++;
        if (busyA !== 1'b1) begin
          errors++; $display("FAIL glitch_busy got %b exp 1", busyA);
        end
      end
    join
    repeat (300) @(negedge clk);
    checks++;
    if ({busyA, ifA.m_valid} !== 2'b00) begin
      errors++; $display("FAIL glitch_nowrite got %b exp 00", {busyA, ifA.m_valid});
    end
  endtask

  task automatic test_parity();
    logic [9:0] exp [3];
    exp[0] = {8'h03, 2'b10};
    exp[1] = {8'h03, 2'b00};
    exp[2] = {8'h5C, 2'b01};
    sendSeq(1, 16, mkB(8'h03, 1'b1, 1'b1), 11);
    sendSeq(1, 16, mkB(8'h03, 1'b0, 1'b1), 11);
    sendSeq(1, 16, mkB(8'h5C, 1'b0, 1'b0), 11);
    rxB = 1'b1;
    repeat (32) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({ifB.m_valid, ifB.m_data, ifB.m_perr, ifB.m_ferr} !== {1'b1, exp[i]}) begin
        errors++; $display("FAIL parity_entry%0d got %h exp %h", i, {ifB.m_valid, ifB.m_data, ifB.m_perr, ifB.m_ferr}, {1'b1, exp[i]});
      end
      pop(1);
    end
    checks++;
    if (ifB.m_valid !== 1'b0) begin
      errors++; $display("FAIL parity_empty got %b exp 0", ifB.m_valid);
    end
  endtask

  task automatic test_break();
    rxB = 1'b0;
    repeat (185) @(negedge clk);
    checks++;
    if ({busyB, ifB.m_valid} !== 2'b01) begin
      errors++; $display("FAIL break_state got %b exp 01", {busyB, ifB.m_valid});
    end
    repeat (7) @(negedge clk);
    rxB = 1'b1;
    repeat (48) @(negedge clk);
    checks++;
    if ({ifB.m_data, ifB.m_perr, ifB.m_ferr} !== {8'h00, 2'b01}) begin
      errors++; $display("FAIL break_entry got %h exp %h", {ifB.m_data, ifB.m_perr, ifB.m_ferr}, {8'h00, 2'b01});
    end
    pop(1);
    checks++;
    if (ifB.m_valid !== 1'b0) begin
      errors++; $display("FAIL break_single got %b exp 0", ifB.m_valid);
    end
  endtask

  task automatic test_back_to_back();
    int ovStart;
    logic [7:0] d;
    ovStart = ovCntB;
    for (int k = 1; k <= 6; k++) begin
      d = 8'(k * 8'h11);
      sendSeq(1, 16, mkB(d, 1'b0, 1'b1), 11);
    end
    repeat (32) @(negedge clk);
    checks++;
    if (ovCntB - ovStart !== 2) begin
      errors++; $display("FAIL overrun_count got %0d exp 2", ovCntB - ovStart);
    end
    ifB.m_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      d = 8'(k * 8'h11);
      checks++;
      if ({ifB.m_valid, ifB.m_data, ifB.m_perr, ifB.m_ferr} !== {1'b1, d, 2'b00}) begin
        errors++; $display("FAIL b2b_pop%0d got %h exp %h", k, {ifB.m_valid, ifB.m_data, ifB.m_perr, ifB.m_ferr}, {1'b1, d, 2'b00});
      end
      @(negedge clk);
    end
    ifB.m_ready = 1'b0;
    checks++;
    if (ifB.m_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_empty got %b exp 0", ifB.m_valid);
    end
  endtask

  task automatic test_msb_odd();
    int ovStart;
    ovStart = ovCntC;
    sendSeq(2, 12, mkC(7'h4B, 1'b1, 1'b1), 11);
    sendSeq(2, 12, mkC(7'h15, 1'b1, 1'b0), 11);
    rxC = 1'b1;
    repeat (24) @(negedge clk);
    sendSeq(2, 12, mkC(7'h2A, 1'b0, 1'b1), 11);
    repeat (24) @(negedge clk);
    checks++;
    if (ovCntC - ovStart !== 1) begin
      errors++; $display("FAIL c_overrun got %0d exp 1", ovCntC - ovStart);
    end
    checks++;
    if ({ifC.m_data, ifC.m_perr, ifC.m_ferr} !== {7'h4B, 2'b00}) begin
      errors++; $display("FAIL c_entry0 got %h exp %h", {ifC.m_data, ifC.m_perr, ifC.m_ferr}, {7'h4B, 2'b00});
    end
    pop(2);
    checks++;
    if ({ifC.m_data, ifC.m_perr, ifC.m_ferr} !== {7'h15, 2'b11}) begin
      errors++; $display("FAIL c_entry1 got %h exp %h", {ifC.m_data, ifC.m_perr, ifC.m_ferr}, {7'h15, 2'b11});
    end
    pop(2);
    checks++;
    if (ifC.m_valid !== 1'b0) begin
      errors++; $display("FAIL c_empty got %b exp 0", ifC.m_valid);
    end
  endtask

  task automatic test_reset_mid_frame();
    sendSeq(1, 16, 16'h000A, 5);
    rxB = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({busyB, ifB.m_valid, ovB} !== 3'b000) begin
      errors++; $display("FAIL midrst_ctl got %b exp 000", {busyB, ifB.m_valid, ovB});
    end
    checks++;
    if ({ifB.m_data, ifB.m_perr, ifB.m_ferr} !== 10'h0) begin
      errors++; $display("FAIL midrst_head got %h exp 0", {ifB.m_data, ifB.m_perr, ifB.m_ferr});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (busyB !== 1'b0) begin
      errors++; $display("FAIL low_line_ignored got %b exp 0", busyB);
    end
    rxB = 1'b1;
    repeat (32) @(negedge clk);
    sendSeq(1, 16, mkB(8'h5A, 1'b0, 1'b1), 11);
    repeat (32) @(negedge clk);
    checks++;
    if ({ifB.m_valid, ifB.m_data, ifB.m_perr, ifB.m_ferr} !== {1'b1, 8'h5A, 2'b00}) begin
      errors++; $display("FAIL after_rst_5a got %h exp %h", {ifB.m_valid, ifB.m_data, ifB.m_perr, ifB.m_ferr}, {1'b1, 8'h5A, 2'b00});
    end
    pop(1);
    checks++;
    if (ifB.m_valid !== 1'b0) begin
      errors++; $display("FAIL after_rst_single got %b exp 0", ifB.m_valid);
    end
  endtask

  initial begin
    ifA.m_ready = 1'b0;
    ifB.m_ready = 1'b0;
    ifC.m_ready = 1'b0;
    test_reset();
    test_timing();
    test_glitch();
    test_parity();
    test_break();
    test_back_to_back();
    test_msb_odd();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver with a built-in receive FIFO. It is the successor to the fixed 8N1, 434-clocks-per-bit receiver under TOP. It sits between the `rxM` pin and the consumer logic that drives `leds` and later blocks. Frame format, bit order, parity, stop bits and buffering are all compile-time parameters. The block adds false-start rejection, error flags and overrun reporting.

## Interface
- CLKS_PER_BIT, 434, clkM cycles per bit; 50 MHz / 115200 baud; must be ≥ 8.
- DATA_BITS, 8, data bits per frame; range 5..9.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, stop bits checked: 1 or 2.
- MSB_FIRST, 0, 1 means the first data bit received is the MSB.
- FIFO_DEPTH, 4, number of FIFO entries; power of two, ≥ 2.
- clkM  in  1  system clock; all logic on the rising edge.
- rst_nM  in  1  reset, asynchronous assert, active-low.
- rxM  in  1  serial input; idles high; asynchronous to clkM.
- m_data  out  DATA_BITS  data at the FIFO head.
- m_perr  out  1  parity error flag for the head entry.
- m_ferr  out  1  framing error flag for the head entry; a stop bit sampled low.
- m_valid  out  1  FIFO not empty.
- m_ready  in  1  consumer accepts the head entry when `m_valid & m_ready`.
- overrun  out  1  one-cycle pulse when a completed frame is dropped because the FIFO is full.
- busy  out  1  receiver is not in IDLE.

## Operation
- rxM passes through a 2-flop synchroniser. Both flops reset to 1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Bit counter `cnt` has width clog2(CLKS_PER_BIT). HALF = CLKS_PER_BIT/2, rounded down.
- **IDLE:** a synchronised 1→0 transition moves the FSM to START with `cnt`=0.
- **START:** when `cnt`=HALF-1, the line is sampled.
  - Line high: false start. Return to IDLE; nothing is written.
  - Line low: go to DATA and reset `cnt`.
- **DATA:** one sample every CLKS_PER_BIT cycles, DATA_BITS samples in total.
  - Bits shift in LSB first, or MSB first if MSB_FIRST=1.
  - After the last bit, go to PARITY if PARITY≠0, otherwise go to STOP.
- **PARITY:** one sample. perr is set when the XOR of the data bits plus the parity bit is wrong for the selected mode:
  - odd mode expects XOR = 1;
  - even mode expects XOR = 0.
- **STOP:** STOP_BITS samples. ferr is set if any stop sample is 0.
  - After the last stop sample the FSM returns to IDLE in the next cycle.
  - A start edge is then accepted immediately, so back-to-back frames are received.
- **Frame complete (last stop-sample cycle):**
  - FIFO not full: write {data, perr, ferr}.
  - FIFO full: drop the frame and pulse `overrun`.
  - If a pop happens in the same cycle as the full condition, the write succeeds.
- Frames with errors are still written, with their flags set. A break (all data bits 0, stop bit 0) appears as data 0 with ferr=1.
- FIFO behaviour:
  - Pop on `m_valid & m_ready`.
  - Simultaneous push and pop is legal at any occupancy.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - Occupancy is tracked with one extra pointer bit.
- Outputs are not registered past the FIFO. `m_data`, `m_perr` and `m_ferr` show the head entry. They hold their previous value when empty.
- **Reset:**
  - FSM goes to IDLE; `cnt`, shift register and FIFO pointers clear.
  - `m_valid`=0, `overrun`=0, `busy`=0; `m_data`, `m_perr`, `m_ferr` = 0.
  - Reset in the middle of a frame discards the partial frame. After release, the receiver waits for a fresh falling edge; a line that is already low is ignored until it returns high.

## Timing
- Let T0 be the first clkM edge on which rxM is low.
  - The synchronised edge is seen at T0+2.
  - The start sample is at T0+2+HALF.
  - Data bit k is sampled at T0+2+HALF+CLKS_PER_BIT·(k+1).
- The FIFO write is registered on the last stop-sample edge. `m_valid` rises 1 cycle later.
- Default 8N1 totals:
  - last stop sample at T0+2+217+434·9 = T0+4125;
  - `m_valid` high at T0+4126.
- Pop takes effect on the clock edge. The next entry, or `m_valid`=0, is visible in the following cycle.
- `busy` rises the cycle after the edge is detected. It falls the cycle after the final stop sample.

## Structure
- Package `uart_pkg` holds:
  - the state enum `rx_state_t`;
  - parity constants PAR_NONE, PAR_ODD, PAR_EVEN;
  - the `rx_entry_t` packing of {data, perr, ferr}.
- Sub-module `rx_fifo`: a synchronous FIFO parametrised by WIDTH and DEPTH, with push/full/pop/empty signals. The FSM and sampler are implemented in `uart_rx_fifo` itself.

## Test plan
- Defaults, frame 0xB5 LSB first (bits 1,0,1,0,1,1,0,1; stop 1) → `m_data`=0xB5, perr=0, ferr=0, `m_valid` rises at T0+4126.
- PARITY=2, frame 0x03 with parity bit 1 → `m_data`=0x03, perr=1; same frame with parity bit 0 → perr=0.
- A 100-cycle low glitch on rxM → `busy` pulses, no FIFO write, `m_valid` stays 0.
- Break: rxM held low for 12 bit times → one entry with data 0x00 and ferr=1, then no further entries until rxM goes high and a new falling edge arrives.
- FIFO_DEPTH=4, `m_ready`=0, six back-to-back frames 0x11..0x66 → 4 entries (0x11..0x44) and two `overrun` pulses; raising `m_ready` then pops 0x11..0x44 in order.
- rst_nM asserted during data bit 4 of 0xA5 → all outputs reset; after release, the next frame 0x5A is received correctly and no partial byte appears.
